// File: rtl/eq_pkg.sv
// Shared constants, types and helpers for the biquad cascade sequencer.
package eq_pkg;

  localparam int unsigned NUM_COEF  = 5;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned FRAC_BITS = 15;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MAC  = 2'd1;
  localparam state_t ST_WB   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Clamp an already-scaled accumulator value into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 40'sd32767) return 16'sh7fff;
    if (v < -40'sd32768) return 16'sh8000;
    return 16'(v);
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Pipelined multiply-accumulate: product and control are registered, the
// 40-bit accumulator folds the registered product in; acc_c is its next value.
module biquad_mac
  import eq_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accumulate,
  input  logic                    subtract,
  input  logic [15:0]             coef,
  input  logic [15:0]             data,
  output logic signed [ACC_W-1:0] acc_c
);

  logic signed [31:0]      prod_d, prod_q;
  logic                    clear_d, clear_q;
  logic                    accumulate_d, accumulate_q;
  logic                    subtract_d, subtract_q;
  logic signed [ACC_W-1:0] base_c, acc_d, acc_q;

  always_comb begin
    prod_d       = $signed(coef) * $signed(data);
    clear_d      = clear;
    accumulate_d = accumulate;
    subtract_d   = subtract;
    base_c       = clear_q ? '0 : acc_q;
    acc_d        = acc_q;
    if (accumulate_q) begin
      acc_d = subtract_q ? base_c - ACC_W'(prod_q) : base_c + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q       <= '0;
      clear_q      <= 1'b0;
      accumulate_q <= 1'b0;
      subtract_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      prod_q       <= prod_d;
      clear_q      <= clear_d;
      accumulate_q <= accumulate_d;
      subtract_q   <= subtract_d;
      acc_q        <= acc_d;
    end
  end

  assign acc_c = acc_d;

endmodule

// File: rtl/biquad_cascade_sequencer.sv
// Time-multiplexed biquad cascade with double-buffered coefficients.
// Define BIQUAD_SAT_EN to saturate each stage result instead of wrapping.
module biquad_cascade_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned COEF_AW    = $clog2(NUM_STAGES * 5)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [15:0]        sample_in,
  output logic               out_valid,
  output logic [15:0]        sample_out,
  output logic               busy,
  input  logic               coef_we,
  input  logic [COEF_AW-1:0] coef_addr,
  input  logic [15:0]        coef_wdata,
  input  logic               coef_commit,
  output logic               coef_committed,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam int unsigned NUM_CW = NUM_STAGES * NUM_COEF;
  localparam int unsigned STG_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [15:0] UNITY  = 16'h7fff;

  state_t                  state_d, state_q;
  logic [STG_W-1:0]        stage_d, stage_q;
  coef_idx_e               idx_d, idx_q;
  logic [15:0]             xin_d, xin_q;
  logic [15:0]             x1_d [NUM_STAGES];
  logic [15:0]             x1_q [NUM_STAGES];
  logic [15:0]             x2_d [NUM_STAGES];
  logic [15:0]             x2_q [NUM_STAGES];
  logic [15:0]             y1_d [NUM_STAGES];
  logic [15:0]             y1_q [NUM_STAGES];
  logic [15:0]             y2_d [NUM_STAGES];
  logic [15:0]             y2_q [NUM_STAGES];
  logic [15:0]             shadow_d [NUM_CW];
  logic [15:0]             shadow_q [NUM_CW];
  logic [15:0]             active_d [NUM_CW];
  logic [15:0]             active_q [NUM_CW];
  logic                    pending_d, pending_q;
  logic                    out_valid_d, out_valid_q;
  logic [15:0]             sample_out_d, sample_out_q;
  logic                    busy_d, busy_q;
  logic                    coef_committed_d, coef_committed_q;
  logic                    overrun_d, overrun_q;
  logic                    copy_c, mac_clear_c, mac_acc_c, mac_sub_c;
  logic [COEF_AW-1:0]      coef_sel_c;
  logic [15:0]             data_c, y_c;
  logic signed [ACC_W-1:0] acc_c;

  // Operand selection for the current stage/coefficient slot.
  always_comb begin
    coef_sel_c = COEF_AW'(stage_q * NUM_COEF + idx_q);
    mac_sub_c  = (idx_q == A1) || (idx_q == A2);
    case (idx_q)
      B0:      data_c = xin_q;
      B1:      data_c = x1_q[stage_q];
      B2:      data_c = x2_q[stage_q];
      A1:      data_c = y1_q[stage_q];
      A2:      data_c = y2_q[stage_q];
      default: data_c = '0;
    endcase
  end

  biquad_mac u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear      (mac_clear_c),
    .accumulate (mac_acc_c),
    .subtract   (mac_sub_c),
    .coef       (active_q[coef_sel_c]),
    .data       (data_c),
    .acc_c      (acc_c)
  );

  always_comb begin
`ifdef BIQUAD_SAT_EN
    y_c = sat16(acc_c >>> FRAC_BITS);
`else
    y_c = 16'(acc_c >>> FRAC_BITS);
`endif
  end

  // Coefficient banks, commit handshake and overrun flag.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    copy_c   = (state_q == ST_IDLE) && pending_q;
    if (copy_c) active_d = shadow_q;
    if (coef_we && (32'(coef_addr) < NUM_CW)) shadow_d[coef_addr] = coef_wdata;
    pending_d        = (pending_q && !copy_c) || coef_commit;
    coef_committed_d = copy_c;
    overrun_d        = (sample_valid && (state_q != ST_IDLE)) || (overrun_q && !overrun_clr);
  end

  // Sequencer: five MAC slots then a write-back per stage, one DONE per sample.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    idx_d        = idx_q;
    xin_d        = xin_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    mac_clear_c  = 1'b0;
    mac_acc_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          xin_d   = sample_in;
          stage_d = '0;
          idx_d   = B0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_acc_c   = 1'b1;
        mac_clear_c = (idx_q == B0);
        if (idx_q == A2) state_d = ST_WB;
        else idx_d = coef_idx_e'(3'(idx_q + 3'd1));
      end
      ST_WB: begin
        x2_d[stage_q] = x1_q[stage_q];
        x1_d[stage_q] = xin_q;
        y2_d[stage_q] = y1_q[stage_q];
        y1_d[stage_q] = y_c;
        xin_d         = y_c;
        idx_d         = B0;
        if (32'(stage_q) == NUM_STAGES - 1) begin
          state_d = ST_DONE;
        end else begin
          stage_d = STG_W'(stage_q + 1'b1);
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        sample_out_d = xin_q;
        out_valid_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      stage_q          <= '0;
      idx_q            <= B0;
      xin_q            <= '0;
      pending_q        <= 1'b0;
      out_valid_q      <= 1'b0;
      sample_out_q     <= '0;
      busy_q           <= 1'b0;
      coef_committed_q <= 1'b0;
      overrun_q        <= 1'b0;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
      for (int unsigned i = 0; i < NUM_CW; i++) begin
        shadow_q[i] <= (i % NUM_COEF == 0) ? UNITY : '0;
        active_q[i] <= (i % NUM_COEF == 0) ? UNITY : '0;
      end
    end else begin
      state_q          <= state_d;
      stage_q          <= stage_d;
      idx_q            <= idx_d;
      xin_q            <= xin_d;
      pending_q        <= pending_d;
      out_valid_q      <= out_valid_d;
      sample_out_q     <= sample_out_d;
      busy_q           <= busy_d;
      coef_committed_q <= coef_committed_d;
      overrun_q        <= overrun_d;
      x1_q             <= x1_d;
      x2_q             <= x2_d;
      y1_q             <= y1_d;
      y2_q             <= y2_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign sample_out     = sample_out_q;
  assign busy           = busy_q;
  assign coef_committed = coef_committed_q;
  assign overrun        = overrun_q;

endmodule

// File: doc/biquad_cascade_sequencer.md
# biquad_cascade_sequencer

Time-multiplexes one 16x16 multiply-accumulate datapath across `NUM_STAGES` cascaded biquad sections, one audio sample at a time. Owns per-stage history and a double-buffered coefficient bank loaded by the MCU-facing register interface. Sits between the audio input deserializer and the output serializer, and replaces one `iir_filter` instance per EQ band.

## Interface
- `NUM_STAGES`, 4: number of cascaded biquad sections (1..8).
- `COEF_AW`, `$clog2(NUM_STAGES*5)`: coefficient address width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe; `sample_in` is valid.
- `sample_in`  in  16  signed input sample.
- `out_valid`  out  1  one-cycle strobe; `sample_out` is valid.
- `sample_out`  out  16  signed filtered sample, held until the next `out_valid`.
- `busy`  out  1  high while a sample is in flight.
- `coef_we`  in  1  write strobe into the shadow bank.
- `coef_addr`  in  COEF_AW  address = stage*5 + index; index order is b0, b1, b2, a1, a2.
- `coef_wdata`  in  16  signed Q1.15 coefficient.
- `coef_commit`  in  1  request to copy the shadow bank into the active bank.
- `coef_committed`  out  1  one-cycle pulse when the copy happens.
- `overrun`  out  1  sticky flag: a sample was dropped.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- Per stage: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - Products are 32-bit; the accumulator is 40-bit signed.
  - Result = acc >>> 15 (arithmetic, floor), then reduced to 16 bits (see Configuration).
- Stage k output is the stage k+1 input. The last stage output drives `sample_out`.
- FSM states:
  - IDLE: wait for `sample_valid`.
  - MAC: 5 cycles, one product per cycle, in b0, b1, b2, a1, a2 order; the accumulator clears on the b0 cycle.
  - WB: 1 cycle. Reduce the result, shift history (x2←x1, x1←x, y2←y1, y1←y), advance the stage counter. Go to MAC, or go to DONE after the last stage.
  - DONE: 1 cycle. Register `sample_out`, pulse `out_valid`, return to IDLE.
- Per-stage history is 4×16-bit, in stage-indexed registers. It is cleared only by reset.
- Coefficient writes:
  - Always go to the shadow bank, even while busy.
  - Writes to `coef_addr` ≥ NUM_STAGES*5 are ignored.
- `coef_commit` sets a pending flag.
  - The copy executes on the first edge where the FSM is in IDLE, and pulses `coef_committed`.
  - A commit never changes coefficients mid-sample.
- `sample_valid` and a pending commit on the same IDLE edge: the commit executes and the sample is accepted. That sample uses the new coefficients.
- `sample_valid` while `busy`: the sample is dropped and `overrun` is set.
  - `overrun_clr` clears `overrun`.
  - If set and clear coincide, set wins.
- Reset values:
  - Outputs: all 0.
  - Shadow and active banks: b0 = 32767, all other coefficients 0 (near-unity passthrough).
  - History: 0. FSM: IDLE. Pending commit: 0.
- A reset mid-sample abandons the sample. No `out_valid` is produced for it.

## Timing
- Sample accepted on edge E0 (IDLE, `sample_valid` = 1). `busy` is high from E0+1.
- `out_valid` is high for exactly the cycle following edge E0 + 6·NUM_STAGES + 1. For NUM_STAGES = 4 that is edge E0+25.
- `busy` falls on the same edge that `out_valid` rises. A new sample is accepted on the very next edge.
- Maximum sample rate is one per 6·NUM_STAGES + 2 clocks.
- `coef_committed` is at most one pulse per commit request. Repeated `coef_commit` pulses while pending coalesce into one.

## Configuration
- `BIQUAD_SAT_EN` defined: each stage result saturates to [−32768, 32767].
- `BIQUAD_SAT_EN` undefined: each stage result keeps bits [30:15] of acc (two's-complement wrap).

## Structure
- Package `eq_pkg` holds:
  - `NUM_COEF` = 5.
  - An enum for coefficient index (B0, B1, B2, A1, A2).
  - `ACC_W` = 40, `FRAC_BITS` = 15.
  - The FSM state typedef.
  - Function `sat16()`.
- Sub-module `biquad_mac`: registered multiplier plus 40-bit accumulator.
  - Inputs: clear, accumulate, subtract.
  - The sequencer owns all control and storage.

## Test plan
- Reset defaults, NUM_STAGES = 4, sample_in = 16384 → `out_valid` 25 cycles later with `sample_out` = 16380. Input −16384 → −16384.
- Stage 0 b0 = 16384, other stage-0 coefficients 0, committed; stages 1-3 at defaults; impulse 32767 then zeros → first output 16380, subsequent outputs 0.
- Saturation: stage 0 b0 = b1 = 32767 and a1 = a2 = 0, stage 0 b2 = 0; stages 1-3 b0 = 32767; NUM_STAGES = 1; samples 30000, 30000. Outputs are 29999, then 32767 with `BIQUAD_SAT_EN`, or the wrapped value −5538 without it.
- Overrun: second `sample_valid` 3 cycles after the first → dropped, `overrun` = 1, only one `out_valid`. `overrun_clr` → 0.
- Commit while busy: shadow b0 = 16384 written and committed mid-sample → the current output uses old coefficients; `coef_committed` pulses at the IDLE edge; the next sample uses the new ones.
- Reset asserted mid-MAC → outputs 0 immediately, no `out_valid`, history cleared. The next sample equals the reset-default result.
